nonce_scheduler: RTL
====================

Name: nonce_scheduler

Overview:
Sequences the double-SHA256 core (sha256_1) across a nonce range for one unit of work. Accepts work (midstate, header tail, target, nonce range), issues one nonce per cycle into the core, and tracks in-flight nonces in order. Compares each returned hash against the target and reports the winning ("golden") nonces upstream. Sits between the work-distribution logic and the hashing core.

Parameters:
INFLIGHT_DEPTH, 128, capacity of the in-flight nonce tag FIFO; must be >= core pipeline latency for full throughput (power of two).
NONCE_W, 32, nonce width.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
work_valid  in  1  work offer
work_ready  out  1  high only in IDLE
work_midstate  in  256  first-chunk midstate
work_tail  in  96  header bytes 64..75 (merkle tail, time, bits)
work_target  in  256  unsigned hit threshold
nonce_start  in  32  first nonce, inclusive
nonce_end  in  32  last nonce, inclusive
abort  in  1  stop current work
core_write_en  out  1  issue strobe to core
core_block_in  out  640  {512'h0, work_tail, nonce}
core_digest_in  out  256  latched midstate
core_digest_out_2  in  256  final hash from core
core_valid_out  in  1  core result strobe, in issue order
found_valid  out  1  golden nonce available
found_nonce  out  32  golden nonce
found_ready  in  1  consumer accepts found
found_overflow  out  1  sticky: hit dropped under backpressure
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of work

Behaviour:
- Reset: the clock and reset are CLK and RST; one clock; reset is synchronous and active-high. On reset: state IDLE, work_ready=1, core_write_en=0, found_valid=0, found_nonce=0, found_overflow=0, busy=0, done=0, tag FIFO empty, core_block_in/core_digest_in=0.
- States: IDLE, RUN, DRAIN.
- IDLE: work_valid & work_ready -> latch midstate, tail, target; cur=nonce_start; remaining=((nonce_end-nonce_start) mod 2^32)+1 (33-bit); clear found_overflow; go to RUN.
- RUN: core_write_en=1 when tag FIFO not full; nonce=cur; push cur into tag FIFO; cur+=1 mod 2^32 (wraps FFFFFFFF->0); remaining-=1. First issue is the cycle after acceptance. remaining reaching 0 -> DRAIN. Tag FIFO full -> core_write_en=0, no advance.
- Range: start==end issues one nonce; start==end+1 issues 2^32 nonces; end<start wraps through 0.
- DRAIN: no issue; when tag FIFO empty -> done=1 for one cycle, go to IDLE.
- Results: on core_valid_out, pop tag FIFO; hit iff core_digest_out_2 <= work_target (unsigned 256-bit, no byte swap). A hit registers found_valid=1 and found_nonce=tag on the next cycle. core_valid_out with tag FIFO empty is ignored.
- Found handshake: found_valid clears on found_ready. If a new hit arrives while found_valid & !found_ready: drop it, set found_overflow=1. A hit arriving in the same cycle as found_ready replaces the held entry without overflow.
- Abort: from RUN, stop issuing that cycle and go to DRAIN; results popped after abort are discarded (no found), and done still pulses when drained. Abort in IDLE or DRAIN has no effect beyond discarding.
- Simultaneous push and pop on the tag FIFO is legal, including when full; count is unchanged.
- Reset mid-run: everything returns to reset values; core results arriving after reset are ignored (tag FIFO empty).

Decomposition:
- miner_pkg: NONCE_W, HASH_W=256, BLOCK_W=640, TAIL_W=96, state enum {IDLE,RUN,DRAIN}.
- Sub-module nonce_tag_fifo: synchronous FIFO, 32-bit width, depth INFLIGHT_DEPTH, full/empty flags, same-cycle push/pop when full.

Test Plan:
- start=end=0x00000005, target=all-ones, mock core latency 4 -> one write_en, found_nonce=0x00000005, done pulse at accept+6.
- start=0x10, end=0x1F, mock hash=0 only for nonce 0x17, target=0 -> 16 consecutive write_en cycles, single found 0x17.
- start=0xFFFFFFFE, end=0x00000001 -> issued nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001, then done.
- target=all-ones, abort after 3 issues -> no further write_en, no found after abort, done after last 3 results.
- found_ready=0, hits on two nonces -> first held in found_nonce, found_overflow=1; next work accept clears it.
- INFLIGHT_DEPTH=4, mock latency 8 -> write_en pattern of 4 on, 4 off; RST mid-RUN -> next cycle all outputs at reset values, later core_valid_out ignored.

Source files
------------

// File: rtl/nonce_scheduler_pkg.sv
// rtl/nonce_scheduler_pkg.sv - shared widths and state encoding for the nonce scheduler
package nonce_scheduler_pkg;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;
  localparam int BLOCK_W = 640;
  localparam int TAIL_W  = 96;
  localparam int PAD_W   = BLOCK_W - TAIL_W - NONCE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;
endpackage

// File: rtl/nonce_tag_fifo.sv
// rtl/nonce_tag_fifo.sv - in-order tag FIFO for nonces in flight through the hashing core
module nonce_tag_fifo #(
  parameter int DEPTH = 128,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a push while full is accepted.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - issues one nonce per cycle into the double-SHA256 core and reports golden nonces
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter int INFLIGHT_DEPTH = 128
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [HASH_W-1:0]  work_midstate,
  input  logic [TAIL_W-1:0]  work_tail,
  input  logic [HASH_W-1:0]  work_target,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               abort,
  output logic               core_write_en,
  output logic [BLOCK_W-1:0] core_block_in,
  output logic [HASH_W-1:0]  core_digest_in,
  input  logic [HASH_W-1:0]  core_digest_out_2,
  input  logic               core_valid_out,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  input  logic               found_ready,
  output logic               found_overflow,
  output logic               busy,
  output logic               done
);
  sched_state_e       state_q, state_d;
  logic [HASH_W-1:0]  midstate_q, midstate_d;
  logic [HASH_W-1:0]  target_q, target_d;
  logic [TAIL_W-1:0]  tail_q, tail_d;
  logic [NONCE_W-1:0] cur_q, cur_d;
  logic [NONCE_W:0]   remaining_q, remaining_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic               found_valid_q, found_valid_d;
  logic               found_overflow_q, found_overflow_d;
  logic               discard_q, discard_d;
  logic               issue, pop, hit, drained;
  logic               fifo_full, fifo_empty;
  logic [NONCE_W-1:0] tag;

  nonce_tag_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .W     (NONCE_W)
  ) u_tag_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (issue),
    .data_i  (cur_q),
    .pop_i   (pop),
    .data_o  (tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop = core_valid_out && !fifo_empty;
  // Results that come back after an abort still retire their tag but never report.
  assign hit = pop && !discard_q && !abort && (core_digest_out_2 <= target_q);

  always_comb begin
    state_d          = state_q;
    midstate_d       = midstate_q;
    target_d         = target_q;
    tail_d           = tail_q;
    cur_d            = cur_q;
    remaining_d      = remaining_q;
    found_nonce_d    = found_nonce_q;
    found_valid_d    = found_valid_q;
    found_overflow_d = found_overflow_q;
    discard_d        = discard_q;
    issue            = 1'b0;
    drained          = 1'b0;

    case (state_q)
      IDLE: begin
        if (work_valid) begin
          midstate_d       = work_midstate;
          target_d         = work_target;
          tail_d           = work_tail;
          cur_d            = nonce_start;
          remaining_d      = {1'b0, nonce_end - nonce_start} + (NONCE_W+1)'(1);
          found_overflow_d = 1'b0;
          discard_d        = 1'b0;
          state_d          = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          discard_d = 1'b1;
          state_d   = DRAIN;
        end else if (!fifo_full || pop) begin
          issue       = 1'b1;
          cur_d       = cur_q + NONCE_W'(1);
          remaining_d = remaining_q - (NONCE_W+1)'(1);
          if (remaining_q == (NONCE_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) discard_d = 1'b1;
        if (fifo_empty) begin
          drained = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hit) begin
      if (found_valid_q && !found_ready) begin
        found_overflow_d = 1'b1;
      end else begin
        found_valid_d = 1'b1;
        found_nonce_d = tag;
      end
    end else if (found_ready) begin
      found_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= IDLE;
      midstate_q       <= '0;
      target_q         <= '0;
      tail_q           <= '0;
      cur_q            <= '0;
      remaining_q      <= '0;
      found_nonce_q    <= '0;
      found_valid_q    <= 1'b0;
      found_overflow_q <= 1'b0;
      discard_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      midstate_q       <= midstate_d;
      target_q         <= target_d;
      tail_q           <= tail_d;
      cur_q            <= cur_d;
      remaining_q      <= remaining_d;
      found_nonce_q    <= found_nonce_d;
      found_valid_q    <= found_valid_d;
      found_overflow_q <= found_overflow_d;
      discard_q        <= discard_d;
    end
  end

  assign work_ready     = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = drained;
  assign core_write_en  = issue;
  assign core_block_in  = {{PAD_W{1'b0}}, tail_q, cur_q};
  assign core_digest_in = midstate_q;
  assign found_valid    = found_valid_q;
  assign found_nonce    = found_nonce_q;
  assign found_overflow = found_overflow_q;
endmodule
